// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC control FSM: states, opcodes,
// ALU-op codes, datapath mux selects and the decoded control word.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd2;
  localparam logic [3:0] OP_OP8I  = 4'd3;
  localparam logic [3:0] OP_OP9I  = 4'd4;
  localparam logic [3:0] OP_LW    = 4'd5;
  localparam logic [3:0] OP_SW    = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALUOP_FUNC = 3'd0;
  localparam logic [2:0] ALUOP_SUB  = 3'd1;
  localparam logic [2:0] ALUOP_SLT  = 3'd2;
  localparam logic [2:0] ALUOP_ADD  = 3'd3;
  localparam logic [2:0] ALUOP_OP8  = 3'd4;
  localparam logic [2:0] ALUOP_OP9  = 3'd5;

  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_ONE   = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_BROFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       halted;
  } ctrl_t;

  function automatic logic [2:0] iTypeAluOp(input logic [3:0] opcode);
    case (opcode)
      OP_SLTI: iTypeAluOp = ALUOP_SLT;
      OP_OP8I: iTypeAluOp = ALUOP_OP8;
      OP_OP9I: iTypeAluOp = ALUOP_OP9;
      default: iTypeAluOp = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Moore decode of FSM state into the datapath control word; FETCH strobes
// are qualified by the memory handshake so PC/IR hold during a fetch stall.
module mc_output_decode
  import multicycle_control_pkg::*;
#(
  parameter logic [2:0] FETCH_ALU_OP = ALUOP_ADD
) (
  input  logic [3:0] state,
  input  logic [2:0] iAluOp,
  input  logic       memReady,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.aluOp = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
        ctrl.aluSrcB = SRCB_ONE;
        ctrl.aluOp   = FETCH_ALU_OP;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_BROFF;
        ctrl.aluOp   = FETCH_ALU_OP;
      end
      S_EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REGB;
        ctrl.aluOp   = ALUOP_FUNC;
      end
      S_EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = iAluOp;
      end
      S_WB_R: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S_WB_I: ctrl.regWrite = 1'b1;
      S_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REGB;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core: sequences fetch/decode/execute/
// memory/writeback, flags undefined opcodes and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int         CNT_W        = 16,
  parameter logic [2:0] FETCH_ALU_OP = ALUOP_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       inp_opcode,
  input  logic             inp_memReady,
  output logic [2:0]       out_aluOp,
  output logic             out_aluSrcA,
  output logic [1:0]       out_aluSrcB,
  output logic             out_pcWrite,
  output logic             out_pcWriteCond,
  output logic [1:0]       out_pcSource,
  output logic             out_iorD,
  output logic             out_memRead,
  output logic             out_memWrite,
  output logic             out_irWrite,
  output logic             out_regWrite,
  output logic             out_regDst,
  output logic             out_memToReg,
  output logic             out_illegal,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_retired
);

  logic [3:0]       state;
  logic [3:0]       stateNext;
  logic [2:0]       iAluOp;
  logic             retire;
  logic             illegalOp;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  ctrl_t            ctrl;

  assign illegalOp = (inp_opcode >= 4'd9) && (inp_opcode <= 4'd14);

  always_comb begin
    stateNext = S_FETCH;
    case (state)
      S_FETCH:  stateNext = inp_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (inp_opcode)
          OP_RTYPE:                         stateNext = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_OP8I, OP_OP9I: stateNext = S_EXEC_I;
          OP_LW, OP_SW:                     stateNext = S_MEM_ADDR;
          OP_BEQ:                           stateNext = S_BRANCH;
          OP_J:                             stateNext = S_JUMP;
          OP_HALT:                          stateNext = S_HALT;
          default:                          stateNext = S_FETCH;
        endcase
      end
      S_EXEC_R: stateNext = S_WB_R;
      S_EXEC_I: stateNext = S_WB_I;
      S_MEM_ADDR: begin
        if (inp_opcode == OP_LW)      stateNext = S_MEM_RD;
        else if (inp_opcode == OP_SW) stateNext = S_MEM_WR;
        else                          stateNext = S_FETCH;
      end
      S_MEM_RD: stateNext = inp_memReady ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: stateNext = inp_memReady ? S_FETCH : S_MEM_WR;
      S_HALT:   stateNext = S_HALT;
      default:  stateNext = S_FETCH;
    endcase
  end

  // Only completed instructions retire; illegal ones return to FETCH from DECODE.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR: retire = inp_memReady;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= stateNext;
      illegal <= (state == S_DECODE) && illegalOp;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // EXEC_I op captured while the opcode is sampled, so later IR changes cannot leak in.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) iAluOp <= iTypeAluOp(inp_opcode);
  end

  mc_output_decode #(
    .FETCH_ALU_OP(FETCH_ALU_OP)
  ) uDecode (
    .state   (state),
    .iAluOp  (iAluOp),
    .memReady(inp_memReady),
    .ctrl    (ctrl)
  );

  assign out_aluOp       = ctrl.aluOp;
  assign out_aluSrcA     = ctrl.aluSrcA;
  assign out_aluSrcB     = ctrl.aluSrcB;
  assign out_pcWrite     = ctrl.pcWrite;
  assign out_pcWriteCond = ctrl.pcWriteCond;
  assign out_pcSource    = ctrl.pcSource;
  assign out_iorD        = ctrl.iorD;
  assign out_memRead     = ctrl.memRead;
  assign out_memWrite    = ctrl.memWrite;
  assign out_irWrite     = ctrl.irWrite;
  assign out_regWrite    = ctrl.regWrite;
  assign out_regDst      = ctrl.regDst;
  assign out_memToReg    = ctrl.memToReg;
  assign out_halted      = ctrl.halted;
  assign out_illegal     = illegal;
  assign out_retired     = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-stream bench for multicycle_control against an
// instruction-level model of phases, control words and retire count.
module tb_multicycle_control;

  typedef enum int {
    K_FETCH, K_DECODE, K_EXEC_R, K_EXEC_I, K_WB_R, K_WB_I, K_MEM_ADDR,
    K_MEM_RD, K_MEM_WB, K_MEM_WR, K_BRANCH, K_JUMP, K_HALT
  } kind_e;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] inp_opcode = 4'd0;
  logic       inp_memReady = 1'b0;
  logic [2:0] out_aluOp;
  logic       out_aluSrcA;
  logic [1:0] out_aluSrcB;
  logic       out_pcWrite, out_pcWriteCond;
  logic [1:0] out_pcSource;
  logic       out_iorD, out_memRead, out_memWrite, out_irWrite;
  logic       out_regWrite, out_regDst, out_memToReg, out_illegal, out_halted;
  logic [3:0] out_retired;

  int         nTests = 0;
  int         nFail = 0;
  logic [3:0] expRetired = 4'd0;
  logic       expIllegal = 1'b0;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .inp_opcode(inp_opcode), .inp_memReady(inp_memReady),
    .out_aluOp(out_aluOp), .out_aluSrcA(out_aluSrcA), .out_aluSrcB(out_aluSrcB),
    .out_pcWrite(out_pcWrite), .out_pcWriteCond(out_pcWriteCond),
    .out_pcSource(out_pcSource), .out_iorD(out_iorD), .out_memRead(out_memRead),
    .out_memWrite(out_memWrite), .out_irWrite(out_irWrite),
    .out_regWrite(out_regWrite), .out_regDst(out_regDst),
    .out_memToReg(out_memToReg), .out_illegal(out_illegal),
    .out_halted(out_halted), .out_retired(out_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return {9'd0, out_retired, out_illegal, out_aluOp, out_aluSrcA, out_aluSrcB,
            out_pcWrite, out_pcWriteCond, out_pcSource, out_iorD, out_memRead,
            out_memWrite, out_irWrite, out_regWrite, out_regDst, out_memToReg,
            out_halted};
  endfunction

  // Expected control word for one phase of an instruction, straight from the phase table.
  function automatic logic [17:0] expCtrl(input kind_e k, input logic mr, input logic [3:0] op);
    logic [2:0] aluOp;
    logic       srcA, pcW, pcWC, iorD, mRd, mWr, irW, rW, rDst, m2r, halt;
    logic [1:0] srcB, pcSrc;
    aluOp = 3'd3; srcA = 0; srcB = 0; pcW = 0; pcWC = 0; pcSrc = 0; iorD = 0;
    mRd = 0; mWr = 0; irW = 0; rW = 0; rDst = 0; m2r = 0; halt = 0;
    case (k)
      K_FETCH:    begin mRd = 1; irW = mr; pcW = mr; srcB = 2'd1; end
      K_DECODE:   srcB = 2'd3;
      K_EXEC_R:   begin srcA = 1; aluOp = 3'd0; end
      K_EXEC_I:   begin
        srcA = 1; srcB = 2'd2;
        aluOp = (op == 4'd1) ? 3'd3 : (op == 4'd2) ? 3'd2 : (op == 4'd3) ? 3'd4 : 3'd5;
      end
      K_WB_R:     begin rW = 1; rDst = 1; end
      K_WB_I:     rW = 1;
      K_MEM_ADDR: begin srcA = 1; srcB = 2'd2; end
      K_MEM_RD:   begin mRd = 1; iorD = 1; end
      K_MEM_WB:   begin rW = 1; m2r = 1; end
      K_MEM_WR:   begin mWr = 1; iorD = 1; end
      K_BRANCH:   begin srcA = 1; aluOp = 3'd1; pcWC = 1; pcSrc = 2'd1; end
      K_JUMP:     begin pcW = 1; pcSrc = 2'd2; end
      K_HALT:     halt = 1;
      default: ;
    endcase
    return {aluOp, srcA, srcB, pcW, pcWC, pcSrc, iorD, mRd, mWr, irW, rW, rDst, m2r, halt};
  endfunction

  function automatic logic [3:0] junk();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of a phase: drive, check mid-cycle, then update the model at the edge.
  task automatic doCycle(input kind_e k, input logic mr, input logic [3:0] op,
                         input logic [3:0] drv, input logic retire);
    inp_memReady = mr;
    inp_opcode   = drv;
    #2;
    chk(k.name(), observed(), {9'd0, expRetired, expIllegal, expCtrl(k, mr, op)});
    expIllegal = (k == K_DECODE) && (op >= 4'd9) && (op <= 4'd14);
    if (retire) expRetired = expRetired + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [3:0] op, input int fs, input int ms);
    for (int i = 0; i <= fs; i++) doCycle(K_FETCH, i == fs, op, junk(), 1'b0);
    doCycle(K_DECODE, rb(), op, op, 1'b0);
    if (op == 4'd0) begin
      doCycle(K_EXEC_R, rb(), op, junk(), 1'b0);
      doCycle(K_WB_R, rb(), op, junk(), 1'b1);
    end else if (op <= 4'd4) begin
      doCycle(K_EXEC_I, rb(), op, junk(), 1'b0);
      doCycle(K_WB_I, rb(), op, junk(), 1'b1);
    end else if (op == 4'd5) begin
      doCycle(K_MEM_ADDR, rb(), op, op, 1'b0);
      for (int i = 0; i <= ms; i++) doCycle(K_MEM_RD, i == ms, op, junk(), 1'b0);
      doCycle(K_MEM_WB, rb(), op, junk(), 1'b1);
    end else if (op == 4'd6) begin
      doCycle(K_MEM_ADDR, rb(), op, op, 1'b0);
      for (int i = 0; i <= ms; i++) doCycle(K_MEM_WR, i == ms, op, junk(), i == ms);
    end else if (op == 4'd7) begin
      doCycle(K_BRANCH, rb(), op, junk(), 1'b1);
    end else if (op == 4'd8) begin
      doCycle(K_JUMP, rb(), op, junk(), 1'b1);
    end else if (op == 4'd15) begin
      for (int i = 0; i < 10; i++) doCycle(K_HALT, rb(), op, junk(), 1'b0);
    end
  endtask

  // Asynchronous reset between edges: outputs must show FETCH before any clock.
  task automatic resetMid(input logic mr);
    inp_memReady = mr;
    inp_opcode   = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk("async_reset", observed(), {9'd0, 4'd0, 1'b0, expCtrl(K_FETCH, mr, 4'd0)});
    #1 rst = 1'b0;
    expRetired = 4'd0;
    expIllegal = 1'b0;
  endtask

  initial begin
    int r;
    logic [3:0] op;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    doCycle(K_FETCH, 1'b1, 4'd0, 4'd0, 1'b0);
    doCycle(K_DECODE, 1'b1, 4'd0, 4'd0, 1'b0);
    resetMid(1'b1);

    runInstr(4'd0, 0, 0);
    runInstr(4'd5, 1, 2);
    runInstr(4'd2, 0, 0);
    runInstr(4'd3, 0, 0);
    runInstr(4'd4, 2, 0);
    runInstr(4'd7, 0, 0);
    runInstr(4'd1, 0, 0);
    runInstr(4'd6, 0, 1);

    // Store interrupted by reset while waiting on memory.
    doCycle(K_FETCH, 1'b1, 4'd6, 4'd6, 1'b0);
    doCycle(K_DECODE, 1'b0, 4'd6, 4'd6, 1'b0);
    doCycle(K_MEM_ADDR, 1'b0, 4'd6, 4'd6, 1'b0);
    doCycle(K_MEM_WR, 1'b0, 4'd6, 4'd6, 1'b0);
    resetMid(1'b0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 8)       op = 4'(r);
      else if (r <= 17) op = 4'($urandom_range(0, 8));
      else              op = 4'($urandom_range(9, 14));
      runInstr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               $urandom_range(0, 3));
    end

    for (int n = 0; n < 16; n++) runInstr(4'd8, 0, 0);

    runInstr(4'd11, 0, 0);
    runInstr(4'd15, 0, 0);
    resetMid(1'b1);
    runInstr(4'd0, 0, 0);
    doCycle(K_FETCH, 1'b0, 4'd0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
